// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Tx channel between N_REQ requesters.
// Optional WAIT_DONE watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ           = 4,
  parameter int REQ_SEL_W       = 2,
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              arb_en_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  input  logic [N_REQ*MAX_UART_DATA_W-1:0]  req_data_i,
  input  logic [N_REQ*TOTAL_CONF_W-1:0]     req_conf_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  output logic [N_REQ-1:0]                  req_done_o,
  output logic                              tx_start_o,
  output logic [MAX_UART_DATA_W-1:0]        tx_data_o,
  output logic [TOTAL_CONF_W-1:0]           tx_conf_o,
  input  logic                              tx_done_i,
  output logic [REQ_SEL_W-1:0]              grant_id_o,
  output logic                              arb_busy_o,
  output logic                              timeout_o
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t                      state, state_nxt;
  logic [REQ_SEL_W-1:0]        last_grant;
  logic [REQ_SEL_W-1:0]        scan_idx;
  logic [REQ_SEL_W-1:0]        win_idx;
  logic                        win_found;
  logic [MAX_UART_DATA_W-1:0]  sel_data;
  logic [TOTAL_CONF_W-1:0]     sel_conf;
  logic                        accept;
  logic                        done_evt;
  logic                        tmo_evt;

  // Search starts just past the last owner so the previous winner ranks last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = REQ_SEL_W'((int'(last_grant) + i) % N_REQ);
      if (!win_found && req_valid_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    sel_data = '0;
    sel_conf = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == REQ_SEL_W'(k)) begin
        sel_data = req_data_i[k*MAX_UART_DATA_W +: MAX_UART_DATA_W];
        sel_conf = req_conf_i[k*TOTAL_CONF_W +: TOTAL_CONF_W];
      end
    end
  end

  assign accept   = (state == IDLE) && arb_en_i && win_found;
  assign done_evt = (state == WAIT_DONE) && tx_done_i;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Completion in the expiry cycle takes precedence over the abort.
  assign tmo_evt = (state == WAIT_DONE) && !tx_done_i &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= tmo_evt;
      if (state == START)          wd_cnt <= '0;
      else if (state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign tmo_evt   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_evt || tmo_evt) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start_o  = (state == START);
    arb_busy_o  = (state != IDLE);
    req_ready_o = '0;
    if (accept && !rst_i) req_ready_o[win_idx] = 1'b1;
  end

  // Character and config are captured on the accept edge and held until the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_data_o  <= '0;
      tx_conf_o  <= '0;
      grant_id_o <= '0;
      last_grant <= REQ_SEL_W'(N_REQ - 1);
      req_done_o <= '0;
    end else begin
      req_done_o <= '0;
      if (accept) begin
        tx_data_o  <= sel_data;
        tx_conf_o  <= sel_conf;
        grant_id_o <= win_idx;
        last_grant <= win_idx;
      end
      if (done_evt) req_done_o[grant_id_o] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// characters checked against a round-robin reference model.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1000000;
`endif

  logic        clk, rst, arb_en, tx_done;
  logic [3:0]  req_valid, req_ready, req_done;
  logic [31:0] req_data;
  logic [19:0] req_conf;
  logic        tx_start, arb_busy, timeout;
  logic [7:0]  tx_data;
  logic [4:0]  tx_conf;
  logic [1:0]  grant_id;

  int nvec = 0;
  int nerr = 0;
  int last = 3;

  uart_tx_arbiter #(.N_REQ(4), .REQ_SEL_W(2), .MAX_UART_DATA_W(8), .TOTAL_CONF_W(5),
                    .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .arb_en_i(arb_en), .req_valid_i(req_valid),
    .req_data_i(req_data), .req_conf_i(req_conf), .req_ready_o(req_ready),
    .req_done_o(req_done), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .tx_conf_o(tx_conf), .tx_done_i(tx_done), .grant_id_o(grant_id),
    .arb_busy_o(arb_busy), .timeout_o(timeout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int         gnt;
    logic [3:0] rdy;
    logic [7:0] exp_d, obs_d;
    logic [4:0] exp_c, obs_c;
    int         starts;
    logic       start_first;
    logic [3:0] done;
  } char_t;

  // Round-robin rule: first valid requester after the last owner, wrapping.
  function automatic int rr_pick(input int lst, input logic [3:0] v);
    for (int i = 1; i <= 4; i++)
      if (v[(lst + i) % 4]) return (lst + i) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; tx_done = 1'b0; arb_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last = 3;
  endtask

  // Drives one character through the arbiter and reports what was observed.
  // Entered and left just after a rising edge.
  task automatic do_char(input logic [3:0] vld, input int dly, input bit hold,
                         input bit noise, output char_t r);
    int n;
    r.gnt = -1; r.rdy = '0; r.exp_d = '0; r.obs_d = '0; r.exp_c = '0; r.obs_c = '0;
    r.starts = 0; r.start_first = 1'b0; r.done = '0;
    req_valid = vld;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    if (req_ready == '0) return;
    r.rdy = req_ready;
    for (int k = 0; k < 4; k++)
      if (req_ready[k]) begin
        r.gnt = k; r.exp_d = req_data[k*8 +: 8]; r.exp_c = req_conf[k*5 +: 5];
      end
    @(posedge clk); #1;
    if (!hold) req_valid = '0;
    req_data = $urandom;
    req_conf = 20'($urandom);
    if (noise) tx_done = 1'b1;
    @(negedge clk);
    r.start_first = tx_start; r.obs_d = tx_data; r.obs_c = tx_conf;
    if (tx_start) r.starts++;
    @(posedge clk); #1;
    tx_done = 1'b0;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk); if (tx_start) r.starts++;
      @(posedge clk); #1;
    end
    tx_done = 1'b1;
    @(negedge clk); if (tx_start) r.starts++;
    @(posedge clk); #1;
    tx_done = 1'b0;
    r.done = req_done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++; if ({req_ready, req_done, tx_start, arb_busy, timeout} !== 11'b0) begin
      nerr++; $display("FAIL reset_ctrl got %b want 0", {req_ready, req_done, tx_start, arb_busy, timeout}); end
    nvec++; if ({tx_data, tx_conf, grant_id} !== 15'b0) begin
      nerr++; $display("FAIL reset_data got %h want 0", {tx_data, tx_conf, grant_id}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    char_t r;
    do_reset();
    req_data = {24'h0, 8'h55}; req_conf = {15'h0, 5'b11000};
    do_char(4'b0001, 3, 1'b0, 1'b0, r);
    nvec++; if (r.rdy !== 4'b0001) begin nerr++; $display("FAIL single_ready got %b want 0001", r.rdy); end
    nvec++; if (r.start_first !== 1'b1 || r.starts != 1) begin
      nerr++; $display("FAIL single_start got first=%b count=%0d want 1/1", r.start_first, r.starts); end
    nvec++; if (r.obs_d !== 8'h55) begin nerr++; $display("FAIL single_data got %h want 55", r.obs_d); end
    nvec++; if (r.obs_c !== 5'b11000) begin nerr++; $display("FAIL single_conf got %b want 11000", r.obs_c); end
    nvec++; if (r.done !== 4'b0001) begin nerr++; $display("FAIL single_done got %b want 0001", r.done); end
    @(posedge clk); #1;
    nvec++; if (req_done !== 4'b0000 || grant_id !== 2'd0) begin
      nerr++; $display("FAIL single_done_width got done=%b gid=%0d want 0000/0", req_done, grant_id); end
    last = 0;
  endtask

  task automatic test_back_to_back();
    char_t r;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_char(4'b1111, 9, 1'b1, 1'b0, r);
      nvec++; if (r.gnt != order[i] || r.starts != 1) begin
        nerr++; $display("FAIL b2b_grant[%0d] got gnt=%0d starts=%0d want %0d/1", i, r.gnt, r.starts, order[i]); end
      nvec++; if (r.done !== 4'(1 << order[i])) begin
        nerr++; $display("FAIL b2b_done[%0d] got %b want %b", i, r.done, 4'(1 << order[i])); end
    end
    req_valid = '0;
  endtask

  task automatic test_skip();
    char_t r;
    int exp [2] = '{3, 1};
    do_reset();
    do_char(4'b0010, 1, 1'b0, 1'b0, r);
    for (int i = 0; i < 2; i++) begin
      do_char(4'b1010, 2, 1'b1, 1'b0, r);
      nvec++; if (r.gnt != exp[i] || r.rdy !== 4'(1 << exp[i])) begin
        nerr++; $display("FAIL skip_grant[%0d] got %0d rdy=%b want %0d", i, r.gnt, r.rdy, exp[i]); end
    end
    req_valid = '0;
    last = 1;
  endtask

  task automatic test_arb_en();
    bit bad = 1'b0;
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL aen_first_ready got %b want 0001", req_ready); end
    @(posedge clk); #1;
    arb_en = 1'b0; req_valid = 4'b0100;
    repeat (3) begin @(posedge clk); #1; end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    nvec++; if (req_done !== 4'b0001) begin nerr++; $display("FAIL aen_done got %b want 0001", req_done); end
    repeat (5) begin
      @(negedge clk); if (req_ready !== 4'b0000 || arb_busy !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    nvec++; if (bad) begin nerr++; $display("FAIL aen_hold got a grant while disabled, want none"); end
    arb_en = 1'b1;
    @(negedge clk);
    nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL aen_resume got %b want 0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
    last = 2;
  endtask

  task automatic test_reset_mid();
    char_t r;
    logic [25:0] obs;
    bit seen = 1'b0;
    do_reset();
    req_data = 32'hA5A5A5A5; req_conf = 20'hFFFFF;
    req_valid = 4'b0100;
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    nvec++; if (arb_busy !== 1'b1 || tx_data !== 8'hA5) begin
      nerr++; $display("FAIL rmid_pre got busy=%b data=%h want 1/a5", arb_busy, tx_data); end
    #2 rst = 1'b1;
    #1 obs = {req_ready, req_done, tx_start, tx_data, tx_conf, grant_id, arb_busy, timeout};
    nvec++; if (obs !== 26'b0) begin nerr++; $display("FAIL rmid_async got %h want 0", obs); end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0; rst = 1'b0;
    repeat (4) begin
      @(negedge clk); if (req_done !== 4'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    nvec++; if (seen) begin nerr++; $display("FAIL rmid_nodone got a done pulse, want none"); end
    do_char(4'b1111, 2, 1'b0, 1'b0, r);
    nvec++; if (r.gnt != 0) begin nerr++; $display("FAIL rmid_first_grant got %0d want 0", r.gnt); end
    last = 0;
  endtask

  task automatic test_random();
    char_t r;
    logic [3:0] v;
    int exp;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      v = 4'($urandom_range(1, 15));
      req_data = $urandom; req_conf = 20'($urandom);
      exp = rr_pick(last, v);
      do_char(v, $urandom_range(0, 6), 1'($urandom), 1'($urandom), r);
      nvec++; if (r.gnt != exp || r.rdy !== 4'(1 << exp)) begin
        nerr++; $display("FAIL rnd_grant[%0d] v=%b got %0d rdy=%b want %0d", i, v, r.gnt, r.rdy, exp); end
      nvec++; if ({r.obs_d, r.obs_c} !== {r.exp_d, r.exp_c}) begin
        nerr++; $display("FAIL rnd_data[%0d] got %h/%h want %h/%h", i, r.obs_d, r.obs_c, r.exp_d, r.exp_c); end
      nvec++; if (r.start_first !== 1'b1 || r.starts != 1) begin
        nerr++; $display("FAIL rnd_start[%0d] got first=%b count=%0d want 1/1", i, r.start_first, r.starts); end
      nvec++; if (r.done !== 4'(1 << exp)) begin
        nerr++; $display("FAIL rnd_done[%0d] got %b want %b", i, r.done, 4'(1 << exp)); end
      if (exp >= 0) last = exp;
    end
    req_valid = '0;
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int tc = -1;
    logic [3:0] rdy_at = '0;
    bit dn = 1'b0;
    do_reset();
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = 4'b0100;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (timeout && tc < 0) begin tc = c; rdy_at = req_ready; end
      if (req_done !== 4'b0) dn = 1'b1;
      @(posedge clk); #1;
    end
    nvec++; if (tc != 18) begin nerr++; $display("FAIL tmo_cycle got %0d want 18", tc); end
    nvec++; if (rdy_at !== 4'b0100) begin nerr++; $display("FAIL tmo_next_grant got %b want 0100", rdy_at); end
    nvec++; if (dn) begin nerr++; $display("FAIL tmo_nodone got a done pulse, want none"); end
    do_reset();
  endtask
`else
  task automatic test_no_timeout();
    bit bad = 1'b0;
    do_reset();
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (40) begin
      @(negedge clk); if (timeout !== 1'b0 || arb_busy !== 1'b1) bad = 1'b1;
      @(posedge clk); #1;
    end
    nvec++; if (bad) begin nerr++; $display("FAIL notmo_wait got an abort or idle, want waiting"); end
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    nvec++; if (req_done !== 4'b0001) begin nerr++; $display("FAIL notmo_done got %b want 0001", req_done); end
  endtask
`endif

  initial begin
    rst = 1'b1; arb_en = 1'b1; tx_done = 1'b0;
    req_valid = '0; req_data = '0; req_conf = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_skip();
    test_arb_en();
    test_reset_mid();
    test_random();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
